// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*      : EX operand forwarding select encodings
//   hz_state_e : memory-wait tracking states
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage ALU result

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for a single EX-stage source operand.
// Ports:
//   rs          : E-stage source register address
//   rd_m, rd_w  : M/W-stage destination register addresses
//   reg_write_m : M-stage instruction writes the register file
//   reg_write_w : W-stage instruction writes the register file
//   sel         : FWD_RF / FWD_W / FWD_M
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        sel
);

  // x0 is hard-wired to zero, so a write to it is never a forwarding source.
  // M is checked first: it holds the younger, more recent value.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for a 5-stage (F/D/E/M/W) RISC-V pipeline.
// Produces EX forwarding selects, load-use stalls, branch flushes and
// data-memory wait stalls; tracks memory waits with a timeout flag and keeps
// saturating stall/flush performance counters.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   Rs_D, Rs_E          : D/E-stage source registers, src i at [i*REG_AW +: REG_AW]
//   RD_E, LoadE, PCSrcE : E-stage destination, load flag, branch taken
//   RD_M, RegWriteM     : M-stage destination and write enable
//   MemReqM, mem_ready  : M-stage data-memory request and completion
//   RD_W, RegWriteW     : W-stage destination and write enable
//   ForwardE            : per-source forwarding select (2 bits each)
//   StallF/D/E/M        : hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W          : clear IF/ID, ID/EX, MEM/WB
//   err_tmo             : sticky memory-wait timeout
//   stall_cnt/flush_cnt : saturating counts of StallF cycles / branch flushes
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int TMO_W   = 8,
  parameter int MEM_TMO = 200,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] Rs_D,
  input  logic [NUM_SRC*REG_AW-1:0] Rs_E,
  input  logic [REG_AW-1:0]         RD_E,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic [REG_AW-1:0]         RD_M,
  input  logic                      RegWriteM,
  input  logic                      MemReqM,
  input  logic                      mem_ready,
  input  logic [REG_AW-1:0]         RD_W,
  input  logic                      RegWriteW,
  output logic [NUM_SRC*2-1:0]      ForwardE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic                      err_tmo,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  // ---------------------------------------------------------------- forwarding
  logic [NUM_SRC*2-1:0] fwd_raw;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
      .rs          (Rs_E[g*REG_AW +: REG_AW]),
      .rd_m        (RD_M),
      .rd_w        (RD_W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .sel         (fwd_raw[g*2 +: 2])
    );
  end

  assign ForwardE = rst ? '0 : fwd_raw;

  // ---------------------------------------------------------- hazard detection
  logic mem_wait;
  logic load_use;
  logic branch;

  assign mem_wait = MemReqM & ~mem_ready;

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (LoadE && (RD_E != '0) && (RD_E == Rs_D[i*REG_AW +: REG_AW])) begin
        load_use = 1'b1;
      end
    end
  end

  // While memory is stalled the taken branch sits frozen in ID/EX, so the
  // redirect is simply applied on the first cycle the wait ends.
  assign branch = PCSrcE & ~mem_wait;

  // Priority: memory wait freezes everything up to M; a taken branch discards
  // the wrong-path D instruction, making any load-use stall on it pointless.
  always_comb begin
    // NOTE: every output is defaulted before the priority chain so that no path
    // leaves one unassigned -- otherwise synthesis infers a latch.
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;  // M is frozen; keep a bubble flowing into W
      end else if (branch) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // ------------------------------------------------------- memory-wait tracker
  hz_state_e        state, state_nxt;
  logic [TMO_W-1:0] wcnt, wcnt_nxt;
  logic             tmo_hit;
  logic             err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // wcnt counts cycles since the request started: the first (RUN) cycle
  // loads 1, so wcnt==MEM_TMO falls on wait cycle MEM_TMO+1.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt != '1) begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  assign tmo_hit = (state == MEM_WAIT) && (wcnt == TMO_W'(MEM_TMO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  // The flag is visible on the very cycle the timeout is reached, then held
  // by err_q until reset.
  assign err_tmo = ~rst & (err_q | tmo_hit);

  // ------------------------------------------------------ performance counters
  // FlushD is raised only by a taken branch, so it marks branch-caused flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (FlushD && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model.
module tb_hazard_ctrl_unit;

  localparam int NS   = 3;
  localparam int AW   = 5;
  localparam int TW   = 3;
  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = 2**CW - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*AW-1:0]  Rs_D, Rs_E;
  logic [AW-1:0]     RD_E, RD_M, RD_W;
  logic              LoadE, PCSrcE, RegWriteM, MemReqM, mem_ready, RegWriteW;
  logic [NS*2-1:0]   ForwardE;
  logic              StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic              err_tmo;
  logic [CW-1:0]     stall_cnt, flush_cnt;

  hazard_ctrl_unit #(
    .REG_AW(AW), .NUM_SRC(NS), .TMO_W(TW), .MEM_TMO(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .Rs_D(Rs_D), .Rs_E(Rs_E), .RD_E(RD_E), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .RD_M(RD_M), .RegWriteM(RegWriteM), .MemReqM(MemReqM),
    .mem_ready(mem_ready), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .err_tmo(err_tmo), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------ model
  // age: how many cycles the current unresolved memory request has been
  // outstanding, counting its first cycle as 1 (0 = none outstanding).
  int m_age, m_stall, m_flush;
  bit m_err;

  function automatic logic [NS*2-1:0] exp_fwd();
    logic [NS*2-1:0] f = '0;
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        if (RegWriteM && RD_M != 0 && RD_M == Rs_E[i*AW +: AW]) f[2*i +: 2] = 2'b10;
        else if (RegWriteW && RD_W != 0 && RD_W == Rs_E[i*AW +: AW]) f[2*i +: 2] = 2'b01;
      end
    end
    return f;
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [6:0] exp_ctl();
    bit mw, lu;
    if (rst) return 7'b0;
    mw = MemReqM && !mem_ready;
    lu = 1'b0;
    for (int i = 0; i < NS; i++)
      if (LoadE && RD_E != 0 && RD_E == Rs_D[i*AW +: AW]) lu = 1'b1;
    if (mw)          return 7'b1111_001;
    else if (PCSrcE) return 7'b0000_110;
    else if (lu)     return 7'b1100_010;
    return 7'b0;
  endfunction

  // Timeout is reached on the (TMO+1)-th cycle a request is outstanding.
  function automatic bit exp_err();
    if (rst) return 1'b0;
    return m_err || (m_age == TMO + 1);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [6:0] c;
    if (rst) begin
      m_age   <= 0;
      m_stall <= 0;
      m_flush <= 0;
      m_err   <= 1'b0;
    end else begin
      c = exp_ctl();
      if (c[6]) m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (c[2]) m_flush <= (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (exp_err()) m_err <= 1'b1;
      if (m_age == 0) m_age <= (MemReqM && !mem_ready) ? 2 : 0;
      else if (mem_ready) m_age <= 0;
      else m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("ForwardE", 32'(ForwardE), 32'(exp_fwd()));
      check("stall_flush", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}),
            32'(exp_ctl()));
      check("err_tmo", 32'(err_tmo), 32'(exp_err()));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs_D = '0; Rs_E = '0; RD_E = '0; RD_M = '0; RD_W = '0;
    LoadE = 0; PCSrcE = 0; RegWriteM = 0; MemReqM = 0; mem_ready = 0; RegWriteW = 0;
  endtask

  bit slow = 1'b0;

  initial begin
    rst = 1'b1;
    idle();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_StallF", 32'(StallF), 0);
    cyc(); rst = 1'b0;

    // forwarding: M wins over W, then W when M targets x0
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs_E[AW-1:0] = 5;
    @(negedge clk); check("fwd_m_wins", 32'(ForwardE[1:0]), 2);
    cyc(); RD_M = 0;
    @(negedge clk); check("fwd_w", 32'(ForwardE[1:0]), 1);

    // load-use on src1
    cyc(); idle(); LoadE = 1; RD_E = 7; Rs_D[2*AW-1:AW] = 7;
    @(negedge clk);
    check("lu_stall", 32'({StallF, StallD, FlushE, StallE}), 32'(4'b1110));
    cyc(); idle();
    @(negedge clk); check("lu_cnt", 32'(stall_cnt), 1);

    // load-use overridden by taken branch
    cyc(); LoadE = 1; RD_E = 7; Rs_D[2*AW-1:AW] = 7; PCSrcE = 1;
    @(negedge clk);
    check("br_over_lu", 32'({FlushD, FlushE, StallF, StallD}), 32'(4'b1100));
    cyc(); idle();
    @(negedge clk); check("br_cnt", 32'(flush_cnt), 1);

    // memory wait with a pending branch: flush deferred until ready
    for (int k = 0; k < 3; k++) begin
      cyc(); idle(); MemReqM = 1; PCSrcE = 1;
      @(negedge clk);
      check("mw_hold", 32'({StallF, StallM, FlushW, FlushD}), 32'(4'b1110));
    end
    cyc(); mem_ready = 1;
    @(negedge clk);
    check("mw_release", 32'({FlushD, FlushE, StallF}), 32'(3'b110));
    cyc(); idle();
    @(negedge clk);
    check("mw_stall_cnt", 32'(stall_cnt), 4);
    check("mw_flush_cnt", 32'(flush_cnt), 2);

    // ready in the first request cycle: no stall
    cyc(); MemReqM = 1; mem_ready = 1;
    @(negedge clk); check("fast_ready", 32'(StallF), 0);

    // timeout on the 5th wait cycle, sticky afterwards
    cyc(); idle(); MemReqM = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); check("tmo_rise", 32'(err_tmo), 32'(k == 5));
      cyc();
    end
    mem_ready = 1;
    @(negedge clk); check("tmo_sticky", 32'(err_tmo), 1);
    cyc(); idle();
    @(negedge clk); check("tmo_sticky_idle", 32'(err_tmo), 1);

    // reset in the middle of a wait
    cyc(); MemReqM = 1; RegWriteM = 1; RD_M = 3; Rs_E[AW-1:0] = 3;
    cyc(); #2 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctl", 32'({ForwardE, StallF, StallM, FlushW, err_tmo}), 0);
    check("rst_mid_cnt", 32'(stall_cnt), 0);
    cyc(); rst = 1'b0;
    @(negedge clk); check("post_rst_run", 32'({StallF, err_tmo}), 32'(2'b10));
    cyc(); mem_ready = 1;
    cyc(); idle();

    // counter saturation
    LoadE = 1; RD_E = 7; Rs_D[AW-1:0] = 7;
    repeat (20) cyc();
    idle();
    @(negedge clk); check("stall_sat", 32'(stall_cnt), 15);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (n % 150 == 0) slow = ~slow;
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NS; i++) begin
        Rs_D[i*AW +: AW] = AW'($urandom_range(0, 3));
        Rs_E[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      RD_E      = AW'($urandom_range(0, 3));
      RD_M      = AW'($urandom_range(0, 3));
      RD_W      = AW'($urandom_range(0, 3));
      LoadE     = ($urandom_range(0, 2) == 0);
      PCSrcE    = ($urandom_range(0, 3) == 0);
      RegWriteM = ($urandom_range(0, 1) == 0);
      RegWriteW = ($urandom_range(0, 1) == 0);
      MemReqM   = slow ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      mem_ready = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0);
    end
    cyc(); idle(); rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
